// File: rtl/ce_scaler_rs_pkg.sv
// Shared CE constants and the saturating truncation helper used by every CE scaler.
// sat_trunc sign-extends a w_in-bit value, clamps it to w_out bits and returns it sign-extended to 64 bits.
package ce_pkg;
  localparam int CE_FFTPTS_W = 12;
  localparam int CE_ERR_W    = 2;

  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                   input int w_in, input int w_out);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = (value <<< (64 - w_in)) >>> (64 - w_in);
    hi = (64'sd1 <<< (w_out - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w_out - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction
endpackage

// File: rtl/ce_scaler_rs_if.sv
// Sink/source streaming bus of the CE output scaler, plus frame tags and saturation statistics.
// slave is the scaler's view, master the producer/consumer view.
interface ce_scaler_rs_if #(
  parameter int wDataIn  = 35,
  parameter int wDataOut = 16,
  parameter int wShift   = 5,
  parameter int wCnt     = 12
);
  import ce_pkg::*;

  logic                   sink_valid;
  logic                   sink_ready;
  logic [CE_ERR_W-1:0]    sink_error;
  logic                   sink_sop;
  logic                   sink_eop;
  logic [wDataIn-1:0]     sink_real;
  logic [wDataIn-1:0]     sink_imag;
  logic [CE_FFTPTS_W-1:0] fftpts_in;
  logic [wShift-1:0]      shift_in;
  logic                   source_valid;
  logic                   source_ready;
  logic [CE_ERR_W-1:0]    source_error;
  logic                   source_sop;
  logic                   source_eop;
  logic [wDataOut-1:0]    source_real;
  logic [wDataOut-1:0]    source_imag;
  logic [CE_FFTPTS_W-1:0] fftpts_out;
  logic [wCnt-1:0]        sat_count;
  logic                   sat_flag;

  modport slave (
    input  sink_valid, sink_error, sink_sop, sink_eop, sink_real, sink_imag,
           fftpts_in, shift_in, source_ready,
    output sink_ready, source_valid, source_error, source_sop, source_eop,
           source_real, source_imag, fftpts_out, sat_count, sat_flag
  );

  modport master (
    output sink_valid, sink_error, sink_sop, sink_eop, sink_real, sink_imag,
           fftpts_in, shift_in, source_ready,
    input  sink_ready, source_valid, source_error, source_sop, source_eop,
           source_real, source_imag, fftpts_out, sat_count, sat_flag
  );
endinterface

// File: rtl/ce_scaler_rs_round_shift.sv
// Stage-1 datapath for one component: round-half-up then arithmetic right shift by s.
// Purely combinational; computed one bit wider than the input so the rounding add cannot overflow.
module ce_round_shift #(
  parameter int W_IN = 35,
  parameter int W_SH = 5
) (
  input  logic signed [W_IN-1:0] x,
  input  logic        [W_SH-1:0] s,
  output logic signed [W_IN:0]   t
);
  logic signed [W_IN:0] xe;
  logic signed [W_IN:0] rnd;

  always_comb begin
    xe  = {x[W_IN-1], x};
    rnd = '0;
    if (s != '0) begin
      rnd = (W_IN + 1)'(1) << (s - 1'b1);
    end
    t = (xe + rnd) >>> s;
  end
endmodule

// File: rtl/ce_scaler_rs.sv
// CE output scaler: per-frame round/shift then saturate; 2-cycle latency, 1 beat/cycle, valid/ready backpressure
// with sink_ready combinational from source_ready. Saturation statistics built only with CE_SCALER_SATCNT_EN.
module ce_scaler_rs
  import ce_pkg::*;
#(
  parameter int wDataIn   = 35,
  parameter int wDataOut  = 16,
  parameter int wShift    = 5,
  parameter int SHIFT_MAX = 24,
  parameter int wCnt      = 12
) (
  input logic         clk,
  input logic         rst_n,
  ce_scaler_rs_if.slave bus
);
  localparam int wT = wDataIn + 1;
  localparam logic [wShift-1:0] SMAX = wShift'(SHIFT_MAX);

  logic adv1, adv2, acc;

  logic [wShift-1:0]      shift_q, shift_d, s_cur;
  logic [CE_FFTPTS_W-1:0] fft_q, fft_d, fft_cur;

  logic                   v1_q, v1_d;
  logic signed [wT-1:0]   t_re, t_im;
  logic signed [wT-1:0]   t_re_q, t_re_d, t_im_q, t_im_d;
  logic [CE_ERR_W-1:0]    err1_q, err1_d;
  logic                   sop1_q, sop1_d, eop1_q, eop1_d;
  logic [CE_FFTPTS_W-1:0] fft1_q, fft1_d;

  logic                   v2_q, v2_d;
  logic [wDataOut-1:0]    re_sat, im_sat;
  logic [wDataOut-1:0]    re2_q, re2_d, im2_q, im2_d;
  logic [CE_ERR_W-1:0]    err2_q, err2_d;
  logic                   sop2_q, sop2_d, eop2_q, eop2_d;
  logic [CE_FFTPTS_W-1:0] fft2_q, fft2_d;

  assign adv2 = !v2_q || bus.source_ready;
  assign adv1 = !v1_q || adv2;
  assign acc  = bus.sink_valid && adv1;

  ce_round_shift #(.W_IN(wDataIn), .W_SH(wShift)) u_rs_re (.x(bus.sink_real), .s(s_cur), .t(t_re));
  ce_round_shift #(.W_IN(wDataIn), .W_SH(wShift)) u_rs_im (.x(bus.sink_imag), .s(s_cur), .t(t_im));

  // A sop beat uses its own shift/fftpts immediately; later beats reuse the latched frame values.
  always_comb begin
    s_cur   = shift_q;
    fft_cur = fft_q;
    if (bus.sink_sop) begin
      s_cur   = (bus.shift_in > SMAX) ? SMAX : bus.shift_in;
      fft_cur = bus.fftpts_in;
    end
    shift_d = shift_q;
    fft_d   = fft_q;
    if (acc) begin
      shift_d = s_cur;
      fft_d   = fft_cur;
    end
  end

  always_comb begin
    v1_d   = v1_q;
    t_re_d = t_re_q;
    t_im_d = t_im_q;
    err1_d = err1_q;
    sop1_d = sop1_q;
    eop1_d = eop1_q;
    fft1_d = fft1_q;
    if (adv1) begin
      v1_d = bus.sink_valid;
    end
    if (acc) begin
      t_re_d = t_re;
      t_im_d = t_im;
      err1_d = bus.sink_error;
      sop1_d = bus.sink_sop;
      eop1_d = bus.sink_eop;
      fft1_d = fft_cur;
    end
  end

  always_comb begin
    re_sat = wDataOut'(sat_trunc(64'(t_re_q), wT, wDataOut));
    im_sat = wDataOut'(sat_trunc(64'(t_im_q), wT, wDataOut));
    v2_d   = v2_q;
    re2_d  = re2_q;
    im2_d  = im2_q;
    err2_d = err2_q;
    sop2_d = sop2_q;
    eop2_d = eop2_q;
    fft2_d = fft2_q;
    if (adv2) begin
      v2_d = v1_q;
    end
    if (adv2 && v1_q) begin
      re2_d  = re_sat;
      im2_d  = im_sat;
      err2_d = err1_q;
      sop2_d = sop1_q;
      eop2_d = eop1_q;
      fft2_d = fft1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      fft_q   <= '0;
      v1_q    <= 1'b0;
      t_re_q  <= '0;
      t_im_q  <= '0;
      err1_q  <= '0;
      sop1_q  <= 1'b0;
      eop1_q  <= 1'b0;
      fft1_q  <= '0;
      v2_q    <= 1'b0;
      re2_q   <= '0;
      im2_q   <= '0;
      err2_q  <= '0;
      sop2_q  <= 1'b0;
      eop2_q  <= 1'b0;
      fft2_q  <= '0;
    end else begin
      shift_q <= shift_d;
      fft_q   <= fft_d;
      v1_q    <= v1_d;
      t_re_q  <= t_re_d;
      t_im_q  <= t_im_d;
      err1_q  <= err1_d;
      sop1_q  <= sop1_d;
      eop1_q  <= eop1_d;
      fft1_q  <= fft1_d;
      v2_q    <= v2_d;
      re2_q   <= re2_d;
      im2_q   <= im2_d;
      err2_q  <= err2_d;
      sop2_q  <= sop2_d;
      eop2_q  <= eop2_d;
      fft2_q  <= fft2_d;
    end
  end

  assign bus.sink_ready   = adv1;
  assign bus.source_valid = v2_q;
  assign bus.source_real  = re2_q;
  assign bus.source_imag  = im2_q;
  assign bus.source_error = err2_q;
  assign bus.source_sop   = sop2_q;
  assign bus.source_eop   = eop2_q;
  assign bus.fftpts_out   = fft2_q;

`ifdef CE_SCALER_SATCNT_EN
  logic            sat2_q, sat2_d, sat_now;
  logic            fire, flag;
  logic [wCnt-1:0] run_q, run_d, cnt_q, cnt_d, base, run_inc;

  // A component clamped iff its saturated value, sign-extended back, differs from t.
  always_comb begin
    sat_now = ({{(wT - wDataOut){re_sat[wDataOut-1]}}, re_sat} != t_re_q) ||
              ({{(wT - wDataOut){im_sat[wDataOut-1]}}, im_sat} != t_im_q);
    sat2_d  = sat2_q;
    if (adv2 && v1_q) begin
      sat2_d = sat_now;
    end
  end

  always_comb begin
    fire    = v2_q && bus.source_ready;
    base    = sop2_q ? '0 : run_q;
    run_inc = (sat2_q && (base != '1)) ? base + wCnt'(1) : base;
    run_d   = run_q;
    cnt_d   = cnt_q;
    flag    = 1'b0;
    if (fire) begin
      run_d = run_inc;
      if (eop2_q) begin
        cnt_d = run_inc;
        flag  = (run_inc != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat2_q <= 1'b0;
      run_q  <= '0;
      cnt_q  <= '0;
    end else begin
      sat2_q <= sat2_d;
      run_q  <= run_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.sat_count = cnt_q;
  assign bus.sat_flag  = flag;
`else
  assign bus.sat_count = '0;
  assign bus.sat_flag  = 1'b0;
`endif
endmodule

// File: tb/tb_ce_scaler_rs.sv
// Directed bench for ce_scaler_rs: rounding, saturation, shift clamp, backpressure, frame switch, mid-frame reset.
module tb_ce_scaler_rs;
  import ce_pkg::*;

`ifdef CE_SCALER_SATCNT_EN
  localparam bit SATCNT = 1'b1;
`else
  localparam bit SATCNT = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ce_scaler_rs_if #(.wDataIn(35), .wDataOut(16), .wShift(5), .wCnt(12)) bus ();

  ce_scaler_rs #(.wDataIn(35), .wDataOut(16), .wShift(5), .SHIFT_MAX(24), .wCnt(12)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sop, input logic eop,
                       input logic [34:0] re, input logic [34:0] im,
                       input logic [4:0] sh, input logic [11:0] fp, input logic [1:0] er);
    bus.sink_valid = v;
    bus.sink_sop   = sop;
    bus.sink_eop   = eop;
    bus.sink_real  = re;
    bus.sink_imag  = im;
    bus.shift_in   = sh;
    bus.fftpts_in  = fp;
    bus.sink_error = er;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  // Single-beat frame; returns with the beat presented at the output.
  task automatic send1(input string tag, input logic [34:0] re, input logic [34:0] im,
                       input logic [4:0] sh, input logic [11:0] fp, input logic [1:0] er);
    drive(1'b1, 1'b1, 1'b1, re, im, sh, fp, er);
    step();
    idle();
    chk({tag, "_lat1_valid"}, bus.source_valid, 1'b0);
    step();
    chk({tag, "_valid"}, bus.source_valid, 1'b1);
  endtask

  logic [31:0] held;
  logic        stalled;
  int          in_i, out_i;
  logic [15:0] exp_re[4];
  logic [11:0] exp_fp[4];
  logic        exp_sop[4];

  initial begin
    idle();
    bus.source_ready = 1'b1;
    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_valid", bus.source_valid, 1'b0);
    chk("rst_real", bus.source_real, 16'h0);
    chk("rst_fftpts", bus.fftpts_out, 12'h0);
    chk("rst_sat_count", bus.sat_count, 12'h0);
    chk("rst_sink_ready", bus.sink_ready, 1'b1);
    rst_n = 1'b1;
    step();

    // Beat before any sop: shift 0 regardless of shift_in.
    drive(1'b1, 1'b0, 1'b0, 35'd5, 35'(-3), 5'd9, 12'd0, 2'd0);
    step();
    idle();
    step();
    chk("presop_real", bus.source_real, 16'd5);
    chk("presop_imag", bus.source_imag, 16'hFFFD);
    step();

    // 1. Rounding.
    send1("round", 35'(98304), 35'(-98304), 5'd16, 12'd64, 2'b10);
    chk("round_real", bus.source_real, 16'd2);
    chk("round_imag", bus.source_imag, 16'hFFFF);
    chk("round_error", bus.source_error, 2'b10);
    chk("round_sopeop", {bus.source_sop, bus.source_eop}, 2'b11);
    chk("round_fftpts", bus.fftpts_out, 12'd64);
    step();

    // 2. Saturation, then a beat just inside the negative limit.
    send1("sat", 35'(64'sd2147483648), 35'(-64'sd4294967296), 5'd16, 12'd64, 2'b00);
    chk("sat_real", bus.source_real, 16'h7FFF);
    chk("sat_imag", bus.source_imag, 16'h8000);
    chk("sat_flag", bus.sat_flag, SATCNT);
    step();
    chk("sat_count", bus.sat_count, SATCNT ? 12'd1 : 12'd0);
    send1("nosat", 35'(-64'sd2147483648), 35'd0, 5'd16, 12'd64, 2'b00);
    chk("nosat_real", bus.source_real, 16'h8000);
    chk("nosat_flag", bus.sat_flag, 1'b0);
    step();
    chk("nosat_count", bus.sat_count, 12'd0);

    // 3. Shift 0, then shift 31 clamped to 24.
    send1("sh0", 35'd100, 35'(-7), 5'd0, 12'd16, 2'b01);
    chk("sh0_real", bus.source_real, 16'd100);
    chk("sh0_imag", bus.source_imag, 16'hFFF9);
    step();
    send1("clamp", 35'(1 << 24), 35'(-(1 << 23)), 5'd31, 12'd16, 2'b00);
    chk("clamp_real", bus.source_real, 16'd1);
    chk("clamp_imag", bus.source_imag, 16'd0);
    step();

    // 4. Backpressure: 64-beat frame, source_ready low for cycles 20..24.
    in_i = 0;
    out_i = 0;
    stalled = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 300 && out_i < 64; cyc++) begin
      bus.source_ready = !(cyc >= 20 && cyc < 25);
      if (in_i < 64) drive(1'b1, in_i == 0, in_i == 63, 35'(in_i * 3 + 1), 35'(-in_i), 5'd0, 12'd64, 2'd0);
      else idle();
      #1;
      if (stalled) chk("bp_hold", {bus.source_valid, bus.source_real, bus.source_imag}, {1'b1, held});
      if (cyc == 20) chk("bp_sink_ready_drop", bus.sink_ready, 1'b0);
      if (bus.source_valid && bus.source_ready) begin
        chk($sformatf("bp_beat%0d", out_i), {bus.source_real, bus.source_imag},
            {16'(out_i * 3 + 1), 16'(-out_i)});
        if (out_i == 0) chk("bp_sop", bus.source_sop, 1'b1);
        if (out_i == 63) chk("bp_eop", bus.source_eop, 1'b1);
        out_i++;
      end
      stalled = bus.source_valid && !bus.source_ready;
      held = {bus.source_real, bus.source_imag};
      if (bus.sink_valid && bus.sink_ready) in_i++;
      step();
    end
    chk("bp_out_count", 64'(out_i), 64'd64);
    bus.source_ready = 1'b1;
    idle();
    step();
    chk("bp_sat_count", bus.sat_count, 12'd0);

    // 5. Back-to-back frames, shift 8 then 16; non-sop shift_in must be ignored.
    exp_re  = '{16'd4, 16'd2, 16'd2, 16'd3};
    exp_fp  = '{12'd128, 12'd128, 12'd256, 12'd256};
    exp_sop = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: drive(1'b1, 1'b1, 1'b0, 35'd1000, 35'd0, 5'd8, 12'd128, 2'd0);
        1: drive(1'b1, 1'b0, 1'b1, 35'd384, 35'd0, 5'd16, 12'd999, 2'd0);
        2: drive(1'b1, 1'b1, 1'b0, 35'd98304, 35'd0, 5'd16, 12'd256, 2'd0);
        3: drive(1'b1, 1'b0, 1'b1, 35'd163840, 35'd0, 5'd8, 12'd7, 2'd0);
        default: idle();
      endcase
      step();
      if (c >= 1) begin
        chk($sformatf("fs_valid%0d", c - 1), bus.source_valid, 1'b1);
        chk($sformatf("fs_real%0d", c - 1), bus.source_real, exp_re[c - 1]);
        chk($sformatf("fs_fftpts%0d", c - 1), bus.fftpts_out, exp_fp[c - 1]);
        chk($sformatf("fs_sop%0d", c - 1), bus.source_sop, exp_sop[c - 1]);
      end
    end
    idle();
    step();

    // 6. Reset in the middle of a shift-4 frame.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, k == 0, 1'b0, 35'(1000 + k), 35'd0, 5'd4, 12'd20, 2'd0);
      step();
    end
    chk("mid_valid_before", bus.source_valid, 1'b1);
    #2 rst_n = 1'b0;
    idle();
    #1;
    chk("mid_rst_valid", bus.source_valid, 1'b0);
    chk("mid_rst_real", bus.source_real, 16'd0);
    chk("mid_rst_fftpts", bus.fftpts_out, 12'd0);
    step();
    rst_n = 1'b1;
    step();
    drive(1'b1, 1'b0, 1'b0, 35'd7, 35'd0, 5'd9, 12'd0, 2'd0);
    step();
    idle();
    step();
    chk("post_rst_shift0", bus.source_real, 16'd7);
    step();
    send1("post_rst", 35'd40, 35'(-40), 5'd4, 12'd32, 2'b00);
    chk("post_rst_real", bus.source_real, 16'd3);
    chk("post_rst_imag", bus.source_imag, 16'hFFFE);
    chk("post_rst_fftpts", bus.fftpts_out, 12'd32);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
